// File: rtl/dsp_addsub_arbiter_pkg.sv
// Shared definitions for the two-port add/sub arbiter and its datapath.
//   DATA_W   : operand/result width
//   op_e     : op-select encoding (ADD=0, SUB=1)
//   state_e  : result-slot FSM encoding (EMPTY=0, FULL=1)
//   xact_t   : one captured transaction (operands, op, issuing port)
package dsp_addsub_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    op_e               op;
    logic              id;
  } xact_t;

endpackage

// File: rtl/dsp_addsub_arbiter_add_sub.sv
// dsp_add_sub: combinational 32-bit adder/subtractor, unsigned wrap, no flags.
//   a, b : operands
//   op   : OP_ADD -> a+b, OP_SUB -> a-b
//   y    : result mod 2^DATA_W
module dsp_add_sub
  import dsp_addsub_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = (op == OP_SUB) ? (a - b) : (a + b);
  end

endmodule

// File: rtl/dsp_addsub_arbiter.sv
// dsp_addsub_arbiter: two requesters share one add/sub unit behind a
// single-entry result slot (one-cycle latency, one result per cycle).
//   clk, reset            : clock, async active-high reset
//   reqN_valid/a/b/sub    : port-N request (sub: 0 = a+b, 1 = a-b)
//   reqN_ready            : port-N accept (at most one high per cycle)
//   rsp_valid/id/data     : result slot, issuing port, result
//   rsp_ready             : consumer accepts result
// RR_ENABLE=1 -> round-robin between contending ports, 0 -> port 0 wins.
module dsp_addsub_arbiter
  import dsp_addsub_arbiter_pkg::*;
#(
  parameter int RR_ENABLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready
);

  state_e state_q, state_d;
  xact_t  xact_q, xact_d;
  logic   rr_last_q;   // port accepted most recently
  logic   gnt;         // index of the port holding the grant
  logic   slot_free;
  logic   accept;

  // Grant is a pure function of the valids and the RR pointer, so ready
  // never depends on operand values.
  always_comb begin
    gnt = 1'b0;
    case ({req1_valid, req0_valid})
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = (RR_ENABLE != 0) ? ~rr_last_q : 1'b0;
      default: gnt = 1'b0;
    endcase
  end

  assign slot_free  = (state_q == ST_EMPTY) | rsp_ready;
  assign req0_ready = ~reset & slot_free & req0_valid & ~gnt;
  assign req1_ready = ~reset & slot_free & req1_valid &  gnt;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_comb begin
    xact_d = gnt ? '{a: req1_a, b: req1_b, op: op_e'(req1_sub), id: 1'b1}
                 : '{a: req0_a, b: req0_b, op: op_e'(req0_sub), id: 1'b0};
  end

  // EMPTY -> FULL on accept; FULL -> EMPTY only on handshake with no accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && rsp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // rr_last_q resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      xact_q    <= '0;
      rr_last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        xact_q    <= xact_d;
        rr_last_q <= gnt;
      end
    end
  end

  dsp_add_sub u_dsp_add_sub (
    .a  (xact_q.a),
    .b  (xact_q.b),
    .op (xact_q.op),
    .y  (rsp_data)
  );

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = xact_q.id;

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share
// stimulus; fixed-priority results are only checked where behaviour differs
// or where both must agree.
module tb_dsp_addsub_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_sub, req1_valid, req1_sub, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        rr_r0, rr_r1, rr_v, rr_id;
  logic [31:0] rr_d;
  logic        fp_r0, fp_r1, fp_v, fp_id;
  logic [31:0] fp_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsp_addsub_arbiter #(.RR_ENABLE(1)) u_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub), .req0_ready(rr_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub), .req1_ready(rr_r1),
    .rsp_valid(rr_v), .rsp_id(rr_id), .rsp_data(rr_d), .rsp_ready(rsp_ready)
  );

  dsp_addsub_arbiter #(.RR_ENABLE(0)) u_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub), .req0_ready(fp_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub), .req1_ready(fp_r1),
    .rsp_valid(fp_v), .rsp_id(fp_id), .rsp_data(fp_d), .rsp_ready(rsp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    step(); step();
    // Reset state, readies held low even with valids up
    chk("rst_valid", {31'd0, rr_v}, 32'd0);
    chk("rst_id",    {31'd0, rr_id}, 32'd0);
    chk("rst_data",  rr_d, 32'd0);
    chk("rst_rdy",   {30'd0, rr_r1, rr_r0}, 32'd0);
    chk("rst_rdy_fp", {30'd0, fp_r1, fp_r0}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    step();

    // Single request on port 0: 5+3
    req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h3; req0_sub = 1'b0;
    #1;
    chk("single_rdy", {30'd0, rr_r1, rr_r0}, 32'd1);
    step();
    req0_valid = 1'b0;
    chk("single_valid", {31'd0, rr_v}, 32'd1);
    chk("single_id",    {31'd0, rr_id}, 32'd0);
    chk("single_data",  rr_d, 32'h8);

    // Wrap on port 1, back-to-back
    req1_valid = 1'b1; req1_a = 32'h0; req1_b = 32'h1; req1_sub = 1'b1;
    step();
    chk("wrap_sub_data", rr_d, 32'hFFFF_FFFF);
    chk("wrap_sub_id",   {31'd0, rr_id}, 32'd1);
    req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; req1_sub = 1'b0;
    step();
    req1_valid = 1'b0;
    chk("wrap_add_data",  rr_d, 32'h0);
    chk("wrap_add_valid", {31'd0, rr_v}, 32'd1);
    step();
    chk("drain_valid", {31'd0, rr_v}, 32'd0);

    // Contention: port 1 went last, so port 0 first, then alternate
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd1; req1_sub = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_valid_%0d", i), {31'd0, rr_v}, 32'd1);
      chk($sformatf("rr_id_%0d", i),    {31'd0, rr_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rr_data_%0d", i),  rr_d, (i % 2 == 0) ? 32'd11 : 32'd9);
      chk($sformatf("rr_onehot_%0d", i), {31'd0, rr_r0 & rr_r1}, 32'd0);
      chk($sformatf("fp_id_%0d", i),    {31'd0, fp_id}, 32'd0);
      chk($sformatf("fp_data_%0d", i),  fp_d, 32'd11);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("cont_drain", {30'd0, fp_v, rr_v}, 32'd0);

    // Backpressure: hold 0x12345678 for three stalled cycles
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h1234_5670; req0_b = 32'h8; req0_sub = 1'b0;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h2; req1_b = 32'h1; req1_sub = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_data_%0d", i), rr_d, 32'h1234_5678);
      chk($sformatf("bp_id_%0d", i),   {31'd0, rr_id}, 32'd0);
      chk($sformatf("bp_rdy_%0d", i),  {30'd0, rr_r1, rr_r0}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {30'd0, rr_r1, rr_r0}, 32'd2);
    step();
    req1_valid = 1'b0;
    chk("bp_swap_valid", {31'd0, rr_v}, 32'd1);
    chk("bp_swap_id",    {31'd0, rr_id}, 32'd1);
    chk("bp_swap_data",  rr_d, 32'h1);

    // Reset with a result pending clears immediately
    rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, rr_v}, 32'd0);
    chk("midrst_data",  rr_d, 32'd0);
    chk("midrst_id",    {31'd0, rr_id}, 32'd0);
    step();
    reset = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd2; req0_sub = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_sub = 1'b0;
    #1;
    chk("postrst_rdy", {30'd0, rr_r1, rr_r0}, 32'd1);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("postrst_id",   {31'd0, rr_id}, 32'd0);
    chk("postrst_data", rr_d, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_addsub_arbiter.md
DSP_ADDSUB_ARBITER -- requirements
Module: dsp_addsub_arbiter

Interface
REQ-001 The block SHALL have parameter RR_ENABLE, default 1, where 1 selects round-robin arbitration and 0 selects fixed priority with port 0 highest.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be:
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- req0_valid  input  1  port-0 request
- req0_a  input  32  port-0 first operand
- req0_b  input  32  port-0 second operand
- req0_sub  input  1  port-0 op select: 0 = a+b, 1 = a-b
- req0_ready  output  1  port-0 accept
- req1_valid, req1_a, req1_b, req1_sub, req1_ready  same as port 0, for port 1
- rsp_valid  output  1  result available
- rsp_id  output  1  port that issued the result
- rsp_data  output  32  result
- rsp_ready  input  1  consumer accepts result

Function
REQ-004 A port's request SHALL be accepted on the rising edge where reqN_valid and reqN_ready are both high.
REQ-005 The slot SHALL be free when rsp_valid is 0, or when rsp_valid and rsp_ready are both 1 in the same cycle.
REQ-006 reqN_ready SHALL be high only when the slot is free and port N holds the grant; at most one reqN_ready SHALL be high in any cycle.
REQ-007 Grant: if only one port is valid, that port SHALL win.
REQ-008 Grant with both ports valid and RR_ENABLE=1: the port not accepted most recently SHALL win.
REQ-009 Grant with both ports valid and RR_ENABLE=0: port 0 SHALL win.
REQ-010 The round-robin pointer SHALL update only on acceptance.
REQ-011 reqN_ready SHALL depend combinationally only on the valids, rsp_valid, rsp_ready and internal state, never on operands.
REQ-012 On acceptance, operands, sub and port id SHALL be captured into operand registers, and rsp_valid SHALL go high on the same edge, giving one-cycle latency.
REQ-013 rsp_data SHALL be the combinational output of the DSP add/sub unit fed from the operand registers: (a ± b) mod 2^32, no carry/overflow flag, unsigned wrap.
REQ-014 While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id SHALL hold stable and no request SHALL be accepted.
REQ-015 If a response handshake and a new acceptance occur on the same edge, the new transaction SHALL replace the old one and rsp_valid SHALL stay 1, sustaining one result per cycle.
REQ-016 If a response handshake occurs with no new acceptance, rsp_valid SHALL fall to 0 on that edge.
REQ-017 Control SHALL be a two-state FSM: EMPTY (rsp_valid=0) goes to FULL on acceptance; FULL goes to EMPTY on a handshake without acceptance; FULL stays FULL on a handshake with acceptance or on stall.
REQ-018 Requesters SHALL hold valid and operands stable until accepted; the arbiter SHALL NOT re-arbitrate away from a stalled requester other than as required by REQ-008 to REQ-010.

Reset
REQ-019 Assertion of reset SHALL immediately force:
- rsp_valid=0, rsp_id=0
- operand registers and sub to 0, so rsp_data=0
- FSM to EMPTY
- round-robin pointer so port 0 wins the first contention
REQ-020 A transaction in flight at reset SHALL be discarded without a response.
REQ-021 Both reqN_ready SHALL be 0 while reset is high.

Structure
REQ-022 Op-select encodings (ADD=0, SUB=1) and FSM state encodings SHALL live in the shared defines include used by the datapath.
REQ-023 The block SHALL instantiate exactly one dsp_add_sub sub-module as its datapath.
REQ-024 Arbitration and FSM logic SHALL be in this module; no other sub-modules.

Verification
REQ-025 Single request: after reset, req0 a=0x00000005, b=0x00000003, sub=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0x00000008.
REQ-026 Wrap: req1 a=0x00000000, b=0x00000001, sub=1 -> rsp_data=0xFFFFFFFF, rsp_id=1; then a=0xFFFFFFFF, b=0x00000001, sub=0 -> rsp_data=0x00000000.
REQ-027 Contention, RR_ENABLE=1, both ports valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,0,1; one result per cycle.
REQ-028 Contention, RR_ENABLE=0 -> rsp_id all 0 while req0_valid stays high.
REQ-029 Backpressure: rsp_ready=0 for 3 cycles with result 0x12345678 -> rsp_data stable, both readies 0; rsp_ready=1 with pending request -> handshake and new acceptance on the same edge.
REQ-030 Reset mid-operation: assert reset while rsp_valid=1 -> rsp_valid=0 and rsp_data=0 immediately; after release, the first contention grants port 0.
